// File: rtl/useq_stack_sequencer.sv
// useq_stack_sequencer: microcode address sequencer with call/return stack, relative branches and wait loops.
module useq_stack_sequencer #(
  parameter int UADDR_W = 14,
  parameter int OPCODE_W = 8,
  parameter int OFFSET_W = 7,
  parameter int COND_N = 16,
  parameter int STACK_DEPTH = 4,
  parameter logic [UADDR_W-1:0] FETCH_ADDR = 14'h0010,
  parameter logic [UADDR_W-1:0] TRAP_ADDR = 14'h0020
) (
  input  logic                               arst,
  input  logic                               clk,
  input  logic                               stall,
  input  logic [2:0]                         typ,
  input  logic [OFFSET_W-1:0]                offset,
  input  logic [$clog2(COND_N)-1:0]          cond_sel,
  input  logic                               cond_invert,
  input  logic                               escape,
  input  logic [COND_N-1:0]                  cond_vec,
  input  logic [OPCODE_W-1:0]                ir,
  input  logic                               dma_req,
  input  logic                               int_pending,
  input  logic                               err_clr,
  output logic [UADDR_W-1:0]                 u_addr,
  output logic                               cond_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_level,
  output logic                               err_overflow,
  output logic                               err_underflow
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam int S = UADDR_W - OPCODE_W;
  localparam logic [2:0] JMP = 3'd0, BR = 3'd1, ENDW = 3'd2, DISP = 3'd3,
                         CALL = 3'd4, RET = 3'd5, CCALL = 3'd6, WAITW = 3'd7;
  logic [UADDR_W-1:0] r_u_addr;
  logic [SP_W-1:0]    r_sp;
  logic               r_err_ovf, r_err_unf;
  logic [UADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [UADDR_W-1:0] w_inc, w_tgt, w_disp, w_next;
  logic [IDX_W-1:0]   w_wr_idx, w_rd_idx;
  logic               w_cond, w_full, w_empty, w_push, w_pop, w_flush, w_ovf, w_unf;
  assign w_cond   = cond_vec[cond_sel] ^ cond_invert;
  assign w_inc    = r_u_addr + UADDR_W'(1);
  assign w_tgt    = r_u_addr + UADDR_W'($signed(offset));
  assign w_disp   = (UADDR_W'(ir) << S) | (UADDR_W'(escape) << (S - 2));
  assign w_full   = r_sp == SP_W'(STACK_DEPTH);
  assign w_empty  = r_sp == '0;
  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));
  always_comb begin
    w_next  = w_inc;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    w_ovf   = 1'b0;
    w_unf   = 1'b0;
    case (typ)
      JMP:   w_next = w_tgt;
      BR:    w_next = w_cond ? w_tgt : w_inc;
      ENDW: begin
        w_next  = (dma_req | int_pending) ? TRAP_ADDR : FETCH_ADDR;
        w_flush = 1'b1;
      end
      DISP:  w_next = w_disp;
      CALL, CCALL: if (typ == CALL || w_cond) begin
        w_next = w_tgt;
        w_push = !w_full;
        w_ovf  = w_full;
      end
      RET: begin
        w_next = w_empty ? TRAP_ADDR : r_stack[w_rd_idx];
        w_pop  = !w_empty;
        w_unf  = w_empty;
      end
      WAITW: w_next = w_cond ? r_u_addr : w_inc;
      default: w_next = w_inc;
    endcase
  end
  // Stack storage needs no reset: sp_level alone defines which entries are live.
  always_ff @(posedge clk)
    if (!stall && w_push) r_stack[w_wr_idx] <= w_inc;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_u_addr  <= '0;
      r_sp      <= '0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (!stall) begin
        r_u_addr <= w_next;
        r_sp     <= w_flush ? '0 : w_push ? r_sp + SP_W'(1) : w_pop ? r_sp - SP_W'(1) : r_sp;
      end
      r_err_ovf <= (w_ovf && !stall) || (r_err_ovf && !err_clr);
      r_err_unf <= (w_unf && !stall) || (r_err_unf && !err_clr);
    end
  end
  assign u_addr        = r_u_addr;
  assign cond_out      = w_cond;
  assign sp_level      = r_sp;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;
endmodule
